// File: rtl/sram_access_ctrl_if.sv
// Request / response port bundle of the SRAM access controller.
//   master : request producer and response consumer (drives req_*, rsp_ready)
//   slave  : the controller (drives req_ready, rsp_valid, rsp_data, rsp_count)
// Request signals: req_valid, req_ready, req_write, req_addr, req_wdata.
// Response signals: rsp_valid, rsp_ready, rsp_data, rsp_count (FIFO occupancy).
interface sram_access_ctrl_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int RSP_DEPTH  = 4
);
  localparam int CNT_WIDTH = $clog2(RSP_DEPTH) + 1;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [CNT_WIDTH-1:0]  rsp_count;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_count
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_count
  );
endinterface

// File: rtl/sram_access_ctrl.sv
// Controller in front of a single-port synchronous SRAM (registered read data,
// one-cycle read latency). Requests are passed straight to the SRAM pins when
// accepted; returning read data is captured into a small response FIFO. A
// credit scheme (FIFO free slots minus the read in flight) throttles requests
// so read data can never be dropped, even when the consumer stalls.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus          : slave side of the request/response bundle
//   sram_a/di/we : address, write data and write enable to the SRAM
//   sram_enable  : SRAM access strobe, asserted only for an accepted request
//   sram_do      : SRAM read data, valid the cycle after a read access
module sram_access_ctrl #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sram_access_ctrl_if.slave     bus,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic [DATA_WIDTH-1:0] sram_di,
  output logic                  sram_enable,
  output logic                  sram_we,
  input  logic [DATA_WIDTH-1:0] sram_do
);

  localparam int PTR_WIDTH = $clog2(RSP_DEPTH);
  localparam int CNT_WIDTH = PTR_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(RSP_DEPTH);

  logic                  rd_pending;
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [CNT_WIDTH-1:0]  count;
  logic [CNT_WIDTH-1:0]  in_use;
  logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];

  logic accept;
  logic push;
  logic pop;

  // Slots already spoken for: queued entries plus the read whose data arrives
  // this cycle. Built from registered state only, so a same-cycle pop does not
  // free a credit and req_ready has no combinational path from rsp_ready.
  assign in_use        = count + CNT_WIDTH'(rd_pending);
  assign bus.req_ready = (in_use < DEPTH_CNT) && rst_n;

  assign accept = bus.req_valid & bus.req_ready;
  assign push   = rd_pending;
  assign pop    = bus.rsp_valid & bus.rsp_ready;

  assign sram_a      = bus.req_addr;
  assign sram_di     = bus.req_wdata;
  assign sram_we     = bus.req_write;
  assign sram_enable = accept;

  assign bus.rsp_valid = (count != '0);
  assign bus.rsp_data  = fifo_mem[rd_ptr];
  assign bus.rsp_count = count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pending <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      // Only reads produce data; an in-flight read lives for exactly one cycle.
      rd_pending <= accept & ~bus.req_write;
      if (push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_WIDTH'(1);
        2'b01:   count <= count - CNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the data array has no reset; validity is tracked by count/pointers,
  // so clearing it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= sram_do;
  end

  // The credit check must make overflow impossible.
  no_push_when_full: assert property (
    @(posedge clk) disable iff (!rst_n) push |-> (count != DEPTH_CNT)
  );

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl with a behavioural SRAM model.
// Unwritten SRAM words read back as (address ^ 16'h5555).
module tb_sram_access_ctrl;
  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sram_access_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(DEPTH)) bus ();

  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_di;
  logic [DW-1:0] sram_do;
  logic          sram_enable;
  logic          sram_we;

  sram_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .sram_a      (sram_a),
    .sram_di     (sram_di),
    .sram_enable (sram_enable),
    .sram_we     (sram_we),
    .sram_do     (sram_do)
  );

  // SRAM macro model: write at the access edge, registered read data.
  bit [DW-1:0] sram_mem [65536];
  bit          written  [65536];
  always @(posedge clk) begin
    if (sram_enable) begin
      if (sram_we) begin
        sram_mem[sram_a] <= sram_di;
        written[sram_a]  <= 1'b1;
      end else begin
        sram_do <= written[sram_a] ? sram_mem[sram_a] : (sram_a ^ 16'h5555);
      end
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic [15:0] a,
                       input logic [15:0] d, input logic rr);
    bus.req_valid = v;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.rsp_ready = rr;
    #1;
  endtask

  task automatic test_reset();
    cyc();
    cyc();
    drive(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1);
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL reset.req_ready: got %b want 0", bus.req_ready); end
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset.rsp_valid: got %b want 0", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_count !== 3'd0) begin n_fail++; $display("FAIL reset.rsp_count: got %0d want 0", bus.rsp_count); end
    n_cmp++; if (sram_enable !== 1'b0) begin n_fail++; $display("FAIL reset.sram_enable: got %b want 0", sram_enable); end
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset.ready_after_release: got %b want 1", bus.req_ready); end
    cyc();
  endtask

  task automatic test_write_read();
    drive(1'b1, 1'b1, 16'h0010, 16'hA5A5, 1'b0);
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL wr_rd.req_ready: got %b want 1", bus.req_ready); end
    n_cmp++; if ({sram_enable, sram_we} !== 2'b11) begin n_fail++; $display("FAIL wr_rd.en_we_write: got %b want 11", {sram_enable, sram_we}); end
    n_cmp++; if (sram_a !== 16'h0010 || sram_di !== 16'hA5A5) begin n_fail++; $display("FAIL wr_rd.a_di: got %h/%h want 0010/a5a5", sram_a, sram_di); end
    cyc();
    drive(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
    n_cmp++; if ({sram_enable, sram_we} !== 2'b10) begin n_fail++; $display("FAIL wr_rd.en_we_read: got %b want 10", {sram_enable, sram_we}); end
    cyc();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_rd.valid_latency1: got %b want 0", bus.rsp_valid); end
    n_cmp++; if (sram_enable !== 1'b0) begin n_fail++; $display("FAIL wr_rd.idle_enable: got %b want 0", sram_enable); end
    cyc();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL wr_rd.valid_latency2: got %b want 1", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_data !== 16'hA5A5) begin n_fail++; $display("FAIL wr_rd.data: got %h want a5a5", bus.rsp_data); end
    n_cmp++; if (bus.rsp_count !== 3'd1) begin n_fail++; $display("FAIL wr_rd.count1: got %0d want 1", bus.rsp_count); end
    cyc();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    n_cmp++; if (bus.rsp_data !== 16'hA5A5 || bus.rsp_count !== 3'd1) begin n_fail++; $display("FAIL wr_rd.stall_hold: got %h/%0d want a5a5/1", bus.rsp_data, bus.rsp_count); end
    cyc();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    n_cmp++; if (bus.rsp_count !== 3'd0 || bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_rd.after_pop: got %0d/%b want 0/0", bus.rsp_count, bus.rsp_valid); end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 12; c++) begin
      if (c < 8) drive(1'b1, 1'b0, 16'(c), 16'h0000, 1'b1);
      else       drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
      if (c < 8) begin
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b.req_ready c=%0d: got %b want 1", c, bus.req_ready); end
      end
      n_cmp++; if (bus.rsp_valid !== 1'((c >= 2) && (c <= 9))) begin n_fail++; $display("FAIL b2b.rsp_valid c=%0d: got %b want %b", c, bus.rsp_valid, (c >= 2) && (c <= 9)); end
      if (c >= 2 && c <= 9) begin
        n_cmp++; if (bus.rsp_data !== (16'(c - 2) ^ 16'h5555)) begin n_fail++; $display("FAIL b2b.rsp_data c=%0d: got %h want %h", c, bus.rsp_data, 16'(c - 2) ^ 16'h5555); end
      end
      cyc();
    end
  endtask

  task automatic test_stall();
    int acc = 0;
    for (int c = 0; c < 8; c++) begin
      drive(1'(acc < 6), 1'b0, 16'(16'h0020 + acc), 16'h0000, 1'b0);
      n_cmp++; if (bus.req_ready !== 1'(c < 4)) begin n_fail++; $display("FAIL stall.req_ready c=%0d: got %b want %b", c, bus.req_ready, c < 4); end
      if (bus.req_valid && bus.req_ready) acc++;
      cyc();
    end
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    n_cmp++; if (acc !== 4) begin n_fail++; $display("FAIL stall.accepted: got %0d want 4", acc); end
    n_cmp++; if (bus.rsp_count !== 3'd4) begin n_fail++; $display("FAIL stall.count_full: got %0d want 4", bus.rsp_count); end
    cyc();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL stall.pop_not_credited: got %b want 0", bus.req_ready); end
    n_cmp++; if (bus.rsp_data !== 16'h5575) begin n_fail++; $display("FAIL stall.data0: got %h want 5575", bus.rsp_data); end
    cyc();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL stall.ready_after_pop: got %b want 1", bus.req_ready); end
    n_cmp++; if (bus.rsp_count !== 3'd3) begin n_fail++; $display("FAIL stall.count3: got %0d want 3", bus.rsp_count); end
    cyc();
    for (int k = 1; k < 4; k++) begin
      drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
      n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== (16'(16'h0020 + k) ^ 16'h5555)) begin n_fail++; $display("FAIL stall.drain k=%0d: got %b/%h want 1/%h", k, bus.rsp_valid, bus.rsp_data, 16'(16'h0020 + k) ^ 16'h5555); end
      cyc();
    end
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    n_cmp++; if (bus.rsp_count !== 3'd0) begin n_fail++; $display("FAIL stall.empty: got %0d want 0", bus.rsp_count); end
  endtask

  task automatic test_alt_wr_rd();
    for (int j = 1; j <= 4; j++) begin
      drive(1'b1, 1'b1, 16'hFFFF, 16'(j), 1'b1);
      n_cmp++; if (bus.req_ready !== 1'b1 || bus.rsp_count !== 3'd0) begin n_fail++; $display("FAIL alt.write j=%0d: got ready %b count %0d want 1/0", j, bus.req_ready, bus.rsp_count); end
      cyc();
      drive(1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b1);
      n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL alt.no_rsp1 j=%0d: got %b want 0", j, bus.rsp_valid); end
      cyc();
      drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
      n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL alt.no_rsp2 j=%0d: got %b want 0", j, bus.rsp_valid); end
      cyc();
      drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
      n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'(j)) begin n_fail++; $display("FAIL alt.data j=%0d: got %b/%h want 1/%h", j, bus.rsp_valid, bus.rsp_data, 16'(j)); end
      cyc();
    end
  endtask

  task automatic test_push_pop_wrap();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 16'(16'h0100 + i), 16'h0000, 1'b0);
      n_cmp++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL wrap.fill i=%0d: got %b want 1", i, bus.req_ready); end
      cyc();
    end
    for (int n = 0; n < 14; n++) begin
      drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
      n_cmp++; if (bus.req_ready !== 1'b0 || bus.rsp_count !== 3'd3) begin n_fail++; $display("FAIL wrap.pp_state n=%0d: got ready %b count %0d want 0/3", n, bus.req_ready, bus.rsp_count); end
      n_cmp++; if (bus.rsp_data !== (16'(16'h0100 + n) ^ 16'h5555)) begin n_fail++; $display("FAIL wrap.data n=%0d: got %h want %h", n, bus.rsp_data, 16'(16'h0100 + n) ^ 16'h5555); end
      cyc();
      drive(1'b1, 1'b0, 16'(16'h0104 + n), 16'h0000, 1'b0);
      n_cmp++; if (bus.rsp_count !== 3'd3 || bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL wrap.after_pp n=%0d: got count %0d ready %b want 3/1", n, bus.rsp_count, bus.req_ready); end
      cyc();
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
      n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== (16'(16'h010E + k) ^ 16'h5555)) begin n_fail++; $display("FAIL wrap.drain k=%0d: got %b/%h want 1/%h", k, bus.rsp_valid, bus.rsp_data, 16'(16'h010E + k) ^ 16'h5555); end
      cyc();
    end
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    n_cmp++; if (bus.rsp_count !== 3'd0) begin n_fail++; $display("FAIL wrap.empty: got %0d want 0", bus.rsp_count); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0);
    cyc();
    drive(1'b1, 1'b0, 16'h0041, 16'h0000, 1'b0);
    cyc();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    cyc();
    drive(1'b1, 1'b0, 16'h0042, 16'h0000, 1'b0);
    n_cmp++; if (bus.rsp_count !== 3'd2 || bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid.setup: got count %0d ready %b want 2/1", bus.rsp_count, bus.req_ready); end
    cyc();
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 16'h0043, 16'h0000, 1'b1);
    n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.rsp_count !== 3'd0) begin n_fail++; $display("FAIL rstmid.cleared: got %b/%0d want 0/0", bus.rsp_valid, bus.rsp_count); end
    n_cmp++; if (bus.req_ready !== 1'b0 || sram_enable !== 1'b0) begin n_fail++; $display("FAIL rstmid.gated: got ready %b en %b want 0/0", bus.req_ready, sram_enable); end
    cyc();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    rst_n = 1'b1;
    cyc();
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
      n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.rsp_count !== 3'd0) begin n_fail++; $display("FAIL rstmid.stray c=%0d: got %b/%0d want 0/0", c, bus.rsp_valid, bus.rsp_count); end
      cyc();
    end
    drive(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1);
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid.fresh_ready: got %b want 1", bus.req_ready); end
    cyc();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    cyc();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'hA5A5) begin n_fail++; $display("FAIL rstmid.fresh_data: got %b/%h want 1/a5a5", bus.rsp_valid, bus.rsp_data); end
    cyc();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    n_cmp++; if (bus.rsp_count !== 3'd0) begin n_fail++; $display("FAIL rstmid.final_empty: got %0d want 0", bus.rsp_count); end
  endtask

  initial begin
    rst_n         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    #1 rst_n = 1'b0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_stall();
    test_alt_wr_rd();
    test_push_pop_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_access_ctrl.md
# sram_access_ctrl

Request-side controller and read-response buffer that sits directly in front of a single-port synchronous SRAM macro (64K x 16 class, registered read data, one-cycle read latency, no reset on data). It accepts read/write requests on a valid/ready port, drives the SRAM enable/write-enable/address/data pins, and captures returning read data into a small response FIFO. It throttles requests with credits so read data is never lost, even when the consumer stalls.

## Interface
- ADDR_WIDTH, 16, SRAM address width
- DATA_WIDTH, 16, SRAM data width
- RSP_DEPTH, 4, response FIFO entries; power of two, >= 2
- CLK  in  1  single clock; all state updates on posedge
- RST_N  in  1  reset, asynchronous assert, active-low
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request this cycle
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  request address
- req_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  response FIFO head valid
- rsp_ready  in  1  consumer takes head this cycle
- rsp_data  out  DATA_WIDTH  read data at FIFO head
- rsp_count  out  clog2(RSP_DEPTH)+1  entries currently in FIFO
- sram_a  out  ADDR_WIDTH  to SRAM A
- sram_di  out  DATA_WIDTH  to SRAM DI
- sram_enable  out  1  to SRAM ENABLE
- sram_we  out  1  to SRAM WE
- sram_do  in  DATA_WIDTH  from SRAM DO

## Operation
- Accept = req_valid & req_ready, sampled at posedge.
- sram_a = req_addr, sram_di = req_wdata, sram_we = req_write: combinational pass-through.
- sram_enable = accept. No other SRAM access is ever issued.
- State: rd_pending (1 bit), FIFO storage, wr_ptr, rd_ptr, count.
- credits = RSP_DEPTH - count - rd_pending, computed from registered state only. A pop in the same cycle is not credited.
- req_ready = (credits > 0) & RST_N. It does not depend on req_valid or req_write. Writes consume no credit but are still gated by req_ready.
- Accepted read: rd_pending <= 1 at that edge. Otherwise rd_pending <= 0.
- Cycle with rd_pending = 1: sram_do is valid and is pushed into the FIFO at the end of that cycle.
- Accepted write: no response and no FIFO entry.
- Pop = rsp_valid & rsp_ready. rsp_valid = (count != 0). rsp_data = FIFO head.
- rsp_data stays stable while rsp_valid & !rsp_ready.
- Push and pop in the same cycle: count is unchanged, pointers both advance, and order is preserved.
- Pointers wrap modulo RSP_DEPTH. The credit rule guarantees a push never finds the FIFO full. Add an assertion for this.
- rsp_ready while empty is ignored.
- Reset asserted, including mid-operation:
  - Immediately clears rd_pending, count and pointers; rsp_valid = 0, req_ready = 0, sram_enable = 0.
  - An in-flight read is discarded. Stale SRAM DO is ignored because rd_pending = 0.
  - SRAM contents are untouched.

## Timing
- Reset values: req_ready 0 (during reset), rsp_valid 0, rsp_count 0, sram_enable 0.
- rsp_data and FIFO storage are not reset. rsp_data is don't-care while rsp_valid = 0.
- First cycle after RST_N deasserts: req_ready = 1.
- Read latency: read accepted at edge k → data pushed at edge k+1 → rsp_valid = 1 in the cycle after edge k+1 (2 cycles, accept to response).
- Write: the SRAM writes at the accept edge. A read of the same address accepted at the next edge returns the new data.
- Throughput: one request per cycle sustained when rsp_ready = 1 continuously (count + rd_pending <= 2 < RSP_DEPTH).
- Stall: with rsp_ready = 0, at most RSP_DEPTH reads are accepted. req_ready drops in the cycle when count + rd_pending = RSP_DEPTH.
- Once stalled, req_ready returns in the cycle after the first pop.

## Test plan
- Reset, then write 0xA5A5 @0x0010, read @0x0010 next cycle → rsp_valid 2 cycles after the read accept, rsp_data = 0xA5A5, rsp_count = 1, then 0 after pop.
- Back-to-back reads @0x0000..0x0007 (preloaded with value = addr ^ 0x5555), rsp_ready = 1 → req_ready never drops; 8 responses in order, one per cycle.
- rsp_ready = 0, 6 reads issued → exactly 4 accepted, req_ready = 0, rsp_count = 4. Pop one → req_ready = 1 the next cycle; all data in order, none lost.
- Alternating write/read to address 0xFFFF with data 0x0001, 0x0002, … → each read returns the preceding write. Writes produce no responses.
- Push and pop in the same cycle with count = 3 → count stays 3, FIFO order intact across pointer wrap (≥ 3 wraps).
- RST_N pulled low the cycle after a read accept with 2 entries queued → rsp_valid = 0, rsp_count = 0 immediately. No stray response after release; a fresh read returns correct data.
